if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 86 ++++++++
 1 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage; owns the PC and the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        dmem_busy,
  input  logic        stall_lw,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        halt_in,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pcplus4,
  output logic        ifid_valid,
  output logic [5:0]  ifid_opc,
  output logic [4:0]  ifid_rs,
  output logic [4:0]  ifid_rt,
  output logic        halted,
  output logic [31:0] fetch_cnt
);
  typedef enum logic {RUN, HALTED} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pcp4_q, pcp4_d, cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_next;
  assign pc_next = pc_q + 32'd4;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (state_q == RUN && !dmem_busy) begin
      if (redirect_en) begin
        pc_d    = redirect_pc;
        instr_d = '0;
        pcp4_d  = '0;
        valid_d = 1'b0;
      end else if (halt_in) begin
        state_d = HALTED;
        instr_d = '0;
        pcp4_d  = '0;
        valid_d = 1'b0;
      end else if (!stall_lw) begin
        // a missed fetch still drains IF/ID to a bubble
        instr_d = ihit ? imemload : '0;
        pcp4_d  = ihit ? pc_next : '0;
        valid_d = ihit;
        pc_d    = ihit ? pc_next : pc_q;
        cnt_d   = ihit ? cnt_q + 32'd1 : cnt_q;
      end
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      pc_q    <= PC_INIT;
      instr_q <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
  assign imemaddr     = pc_q;
  assign imemREN      = (state_q == RUN);
  assign halted       = (state_q == HALTED);
  assign ifid_instr   = instr_q;
  assign ifid_pcplus4 = pcp4_q;
  assign ifid_valid   = valid_q;
  assign ifid_opc     = instr_q[31:26];
  assign ifid_rs      = instr_q[25:21];
  assign ifid_rt      = instr_q[20:16];
  assign fetch_cnt    = cnt_q;
endmodule
